func_equiv_checker: RTL and testbench
=====================================

FUNC_EQUIV_CHECKER -- requirements
Module: func_equiv_checker

Interface
REQ-001 Parameter N_IN, default 3: number of Boolean inputs per function, legal range 1..8.
REQ-002 Parameter N_OUT, default 4: number of outputs per function, legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 tt_a  input  N_OUT*2^N_IN  truth table A; bit v*N_OUT+k is output k for input vector v.
REQ-007 tt_b  input  N_OUT*2^N_IN  truth table B, same layout.
REQ-008 busy  output  1  high in SWEEP and DONE.
REQ-009 done  output  1  one-cycle pulse when results are valid.
REQ-010 equal  output  1  high when the last sweep found no mismatch.
REQ-011 mismatch_cnt  output  N_IN+1  count of vectors with any differing output bit.
REQ-012 mismatch_mask  output  N_OUT  OR over the swept vectors of (A xor B) per output.
REQ-013 first_vec  output  N_IN  lowest mismatching vector; 0 when equal.

Function
REQ-014 FSM states: IDLE, SWEEP, DONE.
REQ-015 IDLE with start=1 at edge k: latch tt_a and tt_b into internal copies, clear vec, mismatch_cnt, mismatch_mask, first_vec and equal, then enter SWEEP.
REQ-016 Later changes to tt_a and tt_b during a sweep have no effect.
REQ-017 SWEEP: each edge compares one vector, ascending from 0, then increments vec.
REQ-018 Per compare, if any bit differs: increment mismatch_cnt, OR the difference into mismatch_mask, and on the first mismatch only load first_vec with vec.
REQ-019 The compare of vector 2^N_IN-1 transitions to DONE; vec wraps to 0 and does not count further.
REQ-020 DONE lasts exactly one cycle: done=1, equal=(mismatch_cnt==0); next edge returns to IDLE.
REQ-021 Without early stop, done is high in the cycle after edge k+2^N_IN.
REQ-022 start while busy is ignored; start held high in IDLE after DONE begins a new sweep.
REQ-023 Result outputs hold their values from DONE until the next accepted start.
REQ-024 mismatch_cnt width N_IN+1 so 2^N_IN mismatches do not overflow.

Reset
REQ-025 rst=1 asynchronously forces IDLE, vec=0, busy=0, done=0, equal=0, mismatch_cnt=0, mismatch_mask=0, first_vec=0, and clears the latched tables.
REQ-026 Reset during SWEEP or DONE aborts the sweep with no done pulse.
REQ-027 After reset release, the first start is accepted normally.

Configuration
REQ-028 Macro FEC_EARLY_STOP_EN, when defined: the first mismatching compare transitions straight to DONE, so mismatch_cnt=1 and mismatch_mask holds that vector's difference only.
REQ-029 Without FEC_EARLY_STOP_EN, a full 2^N_IN sweep always runs.
REQ-030 The macro changes no ports.

Structure
REQ-031 Package fec_pkg holds the state enum (IDLE, SWEEP, DONE) and the state-width localparam.
REQ-032 Sub-module fec_lut_mux, parameterised N_IN and N_OUT, selects the N_OUT-bit slice of a table at vec; it is instantiated twice (A, B) and is combinational.

Verification (N_IN=3, N_OUT=4)
REQ-033 Identical tables: tt_a=tt_b=32'hA5A5_0F0F, start -> done in the cycle after edge k+8, equal=1, mismatch_cnt=0, mismatch_mask=0, first_vec=0.
REQ-034 Single difference: tt_b=tt_a^(1<<22) (vector 5, output 2) -> equal=0, mismatch_cnt=1, mismatch_mask=4'b0100, first_vec=5.
REQ-035 Two differences: tt_b=tt_a^((1<<8)|(1<<27)) -> mismatch_cnt=2, mismatch_mask=4'b1001, first_vec=2. With FEC_EARLY_STOP_EN: done after edge k+3, mismatch_cnt=1, mismatch_mask=4'b0001.
REQ-036 All differ: tt_b=~tt_a -> mismatch_cnt=8 (4'b1000), mismatch_mask=4'hF, first_vec=0.
REQ-037 Start and tables changed while busy: tt_b modified and start pulsed at edge k+3 -> results match the tables latched at k, with a single done pulse.
REQ-038 Reset mid-sweep: rst asserted between edges k+4 and k+5 -> all outputs 0 immediately, no done pulse; a new start completes normally.

Source files
------------

// File: rtl/fec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fec_pkg
//  Description : Shared types for the functional equivalence checker.
//                The sweep FSM state encoding and its width live here.
//  Revision    : 1.0 - initial release
// ============================================================================
package fec_pkg;

    // Width of the sweep FSM state register.
    localparam int FEC_STATE_W = 2;

    // Sweep FSM states.
    typedef enum logic [FEC_STATE_W-1:0] {
        FEC_IDLE  = 2'd0,
        FEC_SWEEP = 2'd1,
        FEC_DONE  = 2'd2
    } fec_state_e;

endpackage : fec_pkg
`default_nettype wire

// File: rtl/fec_lut_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fec_lut_mux
//  Description : Combinational row selector. Returns the N_OUT-bit output
//                word stored for input vector sel in a flattened truth table
//                (row v occupies bits v*N_OUT +: N_OUT).
//  Revision    : 1.0 - initial release
// ============================================================================
module fec_lut_mux
    import fec_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 4
) (
    input  logic [N_OUT*(2**N_IN)-1:0] tt_i,
    input  logic [N_IN-1:0]            sel_i,
    output logic [N_OUT-1:0]           row_o
);

    localparam int N_ROWS = 2**N_IN;

    logic [N_OUT-1:0] w_rows [N_ROWS];

    // Split the flat table into one word per input vector.
    genvar gv;
    generate
        for (gv = 0; gv < N_ROWS; gv++) begin : g_rows
            assign w_rows[gv] = tt_i[gv*N_OUT +: N_OUT];
        end
    endgenerate

    assign row_o = w_rows[sel_i];

endmodule : fec_lut_mux
`default_nettype wire

// File: rtl/func_equiv_checker.sv
`default_nettype none
// ============================================================================
//  Module      : func_equiv_checker
//  Description : Compares two truth tables vector by vector. On an accepted
//                start both tables are captured, then one input vector is
//                compared per clock in ascending order. Reports mismatch
//                count, per-output difference mask, lowest mismatching vector
//                and an equality flag, qualified by a one-cycle done pulse.
//  Options     : FEC_EARLY_STOP_EN - finish the sweep at the first mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module func_equiv_checker
    import fec_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_OUT*(2**N_IN)-1:0] tt_a,
    input  logic [N_OUT*(2**N_IN)-1:0] tt_b,
    output logic                       busy,
    output logic                       done,
    output logic                       equal,
    output logic [N_IN:0]              mismatch_cnt,
    output logic [N_OUT-1:0]           mismatch_mask,
    output logic [N_IN-1:0]            first_vec
);

    localparam int TT_W = N_OUT * (2**N_IN);

`ifdef FEC_EARLY_STOP_EN
    localparam bit EARLY_STOP = 1'b1;
`else
    localparam bit EARLY_STOP = 1'b0;
`endif

    fec_state_e         state_q, state_d;
    logic [TT_W-1:0]    ta_q, ta_d;
    logic [TT_W-1:0]    tb_q, tb_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [N_IN:0]      cnt_q, cnt_d;
    logic [N_OUT-1:0]   mask_q, mask_d;
    logic [N_IN-1:0]    first_q, first_d;
    logic               equal_q, equal_d;

    logic [N_OUT-1:0]   w_row_a;
    logic [N_OUT-1:0]   w_row_b;
    logic [N_OUT-1:0]   w_diff;
    logic               w_miss;
    logic               w_last;

    // Row lookups on the captured copies, so live table changes are ignored.
    fec_lut_mux #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_mux_a (
        .tt_i  (ta_q),
        .sel_i (vec_q),
        .row_o (w_row_a)
    );

    fec_lut_mux #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_mux_b (
        .tt_i  (tb_q),
        .sel_i (vec_q),
        .row_o (w_row_b)
    );

    assign w_diff = w_row_a ^ w_row_b;
    assign w_miss = |w_diff;
    assign w_last = (vec_q == {N_IN{1'b1}});

    // Next-state logic: capture on start, accumulate per vector, finish.
    always_comb begin
        state_d = state_q;
        ta_d    = ta_q;
        tb_d    = tb_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        first_d = first_q;
        equal_d = equal_q;
        case (state_q)
            FEC_IDLE: begin
                if (start) begin
                    state_d = FEC_SWEEP;
                    ta_d    = tt_a;
                    tb_d    = tt_b;
                    vec_d   = '0;
                    cnt_d   = '0;
                    mask_d  = '0;
                    first_d = '0;
                    equal_d = 1'b0;
                end
            end
            FEC_SWEEP: begin
                if (w_miss) begin
                    cnt_d  = cnt_q + 1'b1;
                    mask_d = mask_q | w_diff;
                    // A zero running count means this is the first mismatch.
                    if (cnt_q == '0) begin
                        first_d = vec_q;
                    end
                end
                // Wraps to zero after the last vector.
                vec_d = vec_q + 1'b1;
                if (w_last || (EARLY_STOP && w_miss)) begin
                    state_d = FEC_DONE;
                    equal_d = (cnt_d == '0);
                end
            end
            FEC_DONE: begin
                state_d = FEC_IDLE;
            end
            default: begin
                state_d = FEC_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FEC_IDLE;
            ta_q    <= '0;
            tb_q    <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            first_q <= '0;
            equal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ta_q    <= ta_d;
            tb_q    <= tb_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            first_q <= first_d;
            equal_q <= equal_d;
        end
    end

    assign busy          = (state_q != FEC_IDLE);
    assign done          = (state_q == FEC_DONE);
    assign equal         = equal_q;
    assign mismatch_cnt  = cnt_q;
    assign mismatch_mask = mask_q;
    assign first_vec     = first_q;

endmodule : func_equiv_checker
`default_nettype wire

// File: tb/tb_func_equiv_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_func_equiv_checker
//  Description : Directed self-checking bench for func_equiv_checker with
//                N_IN=3, N_OUT=4. Expected values are hand-computed.
//  Options     : FEC_EARLY_STOP_EN - selects early-stop expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_func_equiv_checker;

    localparam int N_IN  = 3;
    localparam int N_OUT = 4;
    localparam logic [31:0] C_BASE = 32'hA5A5_0F0F;

`ifdef FEC_EARLY_STOP_EN
    localparam bit C_EARLY = 1'b1;
`else
    localparam bit C_EARLY = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [31:0]       tt_a;
    logic [31:0]       tt_b;
    logic              busy;
    logic              done;
    logic              equal;
    logic [N_IN:0]     mismatch_cnt;
    logic [N_OUT-1:0]  mismatch_mask;
    logic [N_IN-1:0]   first_vec;

    int checks   = 0;
    int failures = 0;

    func_equiv_checker #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .tt_a          (tt_a),
        .tt_b          (tt_b),
        .busy          (busy),
        .done          (done),
        .equal         (equal),
        .mismatch_cnt  (mismatch_cnt),
        .mismatch_mask (mismatch_mask),
        .first_vec     (first_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Start a sweep (edge k is the first posedge after the call) and wait
    // for done, sampling at negedges. lat = posedges after k until done seen.
    task automatic run_sweep(input logic [31:0] a, input logic [31:0] b, output int lat);
        lat = -1;
        @(negedge clk);
        tt_a  = a;
        tt_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Verify result outputs, then that done drops and results hold after it.
    task automatic check_results(input string tag, input int lat, input int exp_lat,
                                 input logic exp_eq, input logic [3:0] exp_cnt,
                                 input logic [3:0] exp_mask, input logic [2:0] exp_first);
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_busy"}, busy, 1'b1);
        check_eq({tag, "_equal"}, equal, exp_eq);
        check_eq({tag, "_cnt"}, mismatch_cnt, exp_cnt);
        check_eq({tag, "_mask"}, mismatch_mask, exp_mask);
        check_eq({tag, "_first"}, first_vec, exp_first);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 1'b0);
        check_eq({tag, "_idle"}, busy, 1'b0);
        check_eq({tag, "_hold_cnt"}, mismatch_cnt, exp_cnt);
        check_eq({tag, "_hold_eq"}, equal, exp_eq);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] b;

        rst   = 1'b1;
        start = 1'b0;
        tt_a  = '0;
        tt_b  = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_equal", equal, 1'b0);
        check_eq("rst_cnt", mismatch_cnt, 4'd0);
        check_eq("rst_mask", mismatch_mask, 4'd0);
        check_eq("rst_first", first_vec, 3'd0);
        rst = 1'b0;

        // Identical tables.
        run_sweep(C_BASE, C_BASE, lat);
        check_results("ident", lat, 8, 1'b1, 4'd0, 4'h0, 3'd0);

        // Single difference: vector 5, output 2.
        run_sweep(C_BASE, C_BASE ^ (32'd1 << 22), lat);
        check_results("single", lat, C_EARLY ? 6 : 8, 1'b0, 4'd1, 4'b0100, 3'd5);

        // Two differences: vector 2 output 0, vector 6 output 3.
        run_sweep(C_BASE, C_BASE ^ ((32'd1 << 8) | (32'd1 << 27)), lat);
        if (C_EARLY)
            check_results("two", lat, 3, 1'b0, 4'd1, 4'b0001, 3'd2);
        else
            check_results("two", lat, 8, 1'b0, 4'd2, 4'b1001, 3'd2);

        // Every bit differs.
        run_sweep(C_BASE, ~C_BASE, lat);
        if (C_EARLY)
            check_results("all", lat, 1, 1'b0, 4'd1, 4'hF, 3'd0);
        else
            check_results("all", lat, 8, 1'b0, 4'd8, 4'hF, 3'd0);

        // Tables changed and start re-pulsed while busy.
        @(negedge clk);
        tt_a  = C_BASE;
        tt_b  = C_BASE;
        start = 1'b1;
        @(posedge clk);                 // edge k
        #1 start = 1'b0;
        repeat (2) @(posedge clk);      // edges k+1, k+2
        @(negedge clk);
        tt_b  = ~C_BASE;
        start = 1'b1;
        @(posedge clk);                 // edge k+3
        #1 start = 1'b0;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check_eq("busyupd_equal", equal, 1'b1);
                check_eq("busyupd_cnt", mismatch_cnt, 4'd0);
            end
        end
        check_eq("busyupd_pulses", pulses, 1);

        // Reset between edges k+4 and k+5.
        @(negedge clk);
        tt_a  = C_BASE;
        tt_b  = ~C_BASE;
        start = 1'b1;
        @(posedge clk);                 // edge k
        #1 start = 1'b0;
        repeat (4) @(posedge clk);      // edges k+1..k+4
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_done", done, 1'b0);
        check_eq("midrst_cnt", mismatch_cnt, 4'd0);
        check_eq("midrst_mask", mismatch_mask, 4'd0);
        check_eq("midrst_first", first_vec, 3'd0);
        check_eq("midrst_equal", equal, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_eq("midrst_no_done", pulses, 0);

        // Fresh sweep after reset completes normally.
        b = C_BASE ^ (32'd1 << 22);
        run_sweep(C_BASE, b, lat);
        check_results("post_rst", lat, C_EARLY ? 6 : 8, 1'b0, 4'd1, 4'b0100, 3'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_func_equiv_checker
`default_nettype wire
